// File: rtl/down_counter_pkg.sv
// Shared counter package: FSM state encoding and default width, common to the
// up- and down-counters of this datapath.
package down_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_e;

  localparam int CNT_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with registered terminal-count pulse and optional
// auto-reload for use as a periodic timebase.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH_DEFAULT,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_clear,
  input  logic             io_load,
  input  logic [WIDTH-1:0] io_load_val,
  output logic [WIDTH-1:0] io_out,
  output logic             io_zero,
  output logic             io_busy,
  output logic             io_done
);

  cnt_state_e       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             done;
  logic             tick;
  logic             terminal;

  // Decrement that holds at zero, so a corrupted state can never wrap.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign tick     = io_en && (state == RUN) && !io_clear && !io_load;
  assign terminal = (count == WIDTH'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (io_clear) begin
        count <= '0;
        state <= IDLE;
      end else if (io_load) begin
        count  <= io_load_val;
        reload <= io_load_val;
        state  <= (io_load_val != '0) ? RUN : IDLE;
      end else if (tick) begin
        if (terminal) begin
          done <= 1'b1;
          if (AUTO_RELOAD) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end else if (count == '0) begin
          // Unreachable in normal operation; fall back to a safe idle.
          state <= IDLE;
        end else begin
          count <= sat_dec(count);
        end
      end
    end
  end

  assign io_out  = count;
  assign io_zero = (count == '0);
  assign io_busy = (state == RUN);
  assign io_done = done;

endmodule
